// File: rtl/boot_image_loader.sv
// boot_image_loader: copies IMAGE_LEN words from ROM to a destination port, then pulses execute_enable.
module boot_image_loader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int IMAGE_LEN  = 276,
    parameter int ROM_LAT    = 1,
    parameter int DEST_BASE  = 0,
    parameter int EXEC_ADDR  = 0,
    parameter int AUTO_START = 1
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              dn_go,
    output logic              dn_wr,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [DATA_W-1:0] dn_data,
    input  logic              dn_wait,
    output logic              execute_enable,
    output logic [ADDR_W-1:0] execute_addr,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, EXEC, DONE} state_t;
    localparam logic [ADDR_W:0]   LEN      = (ADDR_W+1)'(IMAGE_LEN);
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(DEST_BASE);
    localparam logic [1:0]        LAT_LAST = 2'(ROM_LAT - 1);
    localparam state_t            FIRST    = (IMAGE_LEN == 0) ? EXEC : FETCH;
    state_t            state, state_nx;
    logic [ADDR_W:0]   idx, idx_nx;
    logic [1:0]        lat, lat_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] data_nx;
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        lat_nx   = '0;
        addr_nx  = dn_addr;
        data_nx  = dn_data;
        case (state)
            IDLE, DONE: if (start || (state == IDLE && AUTO_START != 0)) begin
                idx_nx   = '0;
                state_nx = FIRST;
            end
            FETCH: if (lat == LAT_LAST) begin
                addr_nx  = BASE + idx[ADDR_W-1:0];
                data_nx  = rom_data;
                state_nx = WRITE;
            end else begin
                lat_nx = lat + 2'd1;
            end
            WRITE: if (!dn_wait) begin
                idx_nx   = idx + ONE;
                state_nx = (idx + ONE == LEN) ? EXEC : FETCH;
            end
            EXEC:    state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= '0;
            lat     <= '0;
            dn_addr <= '0;
            dn_data <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            lat     <= lat_nx;
            dn_addr <= addr_nx;
            dn_data <= data_nx;
        end
    end
    assign rom_addr       = idx[ADDR_W-1:0];
    assign dn_go          = state == FETCH || state == WRITE;
    assign dn_wr          = state == WRITE;
    assign execute_enable = state == EXEC;
    assign done           = state == DONE;
    assign execute_addr   = ADDR_W'(EXEC_ADDR);
endmodule

// File: tb/tb_boot_image_loader.sv
// tb_boot_image_loader: checks boot_image_loader under five parameter sets against a word-list reference model.
module tb_boot_image_loader;
    typedef struct packed {logic [15:0] a; logic [7:0] d;} wr_t;
    typedef struct {logic start; logic exe; logic done; logic go;} vec_t;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    int errs = 0, checks = 0;
    logic zero = 1'b0;

    function automatic logic [7:0] rom_f(input logic [15:0] a);
        return 8'(a * 16'd7 + (a >> 8) * 16'd13 + 16'h5A);
    endfunction

    function automatic wr_t exp_wr(input logic [15:0] base, input int i);
        return {base + 16'(i), rom_f(16'(i))};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cmp_copy(input string nm, input wr_t q[$], input int off, input int len, input logic [15:0] base);
        for (int i = 0; i < len; i++)
            check($sformatf("%s word %0d", nm, i), (off + i < q.size()) ? 32'(q[off + i]) : 32'hDEAD_BEEF,
                  32'(exp_wr(base, i)));
    endtask

    logic rst_n0 = 0, go0, wr0, exe0, done0;
    logic rst_n1 = 0, wait1 = 0, go1, wr1, exe1, done1;
    logic rst_n2 = 0, start2 = 0, go2, wr2, exe2, done2;
    logic rst_n3 = 0, go3, wr3, exe3, done3;
    logic rst_n4 = 0, start4 = 0, go4, wr4, exe4, done4;
    logic [15:0] ra0, da0, xa0, ra1, da1, xa1, ra2, da2, xa2, ra3, da3, xa3, ra4, da4, xa4;
    logic [7:0]  rd0, dd0, rd1, dd1, rd2, dd2, rd3, dd3, rd4, dd4;
    logic [15:0] a1d1, a1d2;

    assign rd0 = rom_f(ra0);
    assign rd2 = rom_f(ra2);
    assign rd3 = rom_f(ra3);
    assign rd4 = rom_f(ra4);
    always @(posedge clk_sys) begin
        a1d1 <= ra1;
        a1d2 <= a1d1;
    end
    assign rd1 = rom_f(a1d2);

    boot_image_loader u0 (
        .clk_sys(clk_sys), .reset_n(rst_n0), .start(zero), .rom_addr(ra0), .rom_data(rd0),
        .dn_go(go0), .dn_wr(wr0), .dn_addr(da0), .dn_data(dd0), .dn_wait(zero),
        .execute_enable(exe0), .execute_addr(xa0), .done(done0));
    boot_image_loader #(.ROM_LAT(3), .IMAGE_LEN(40)) u1 (
        .clk_sys(clk_sys), .reset_n(rst_n1), .start(zero), .rom_addr(ra1), .rom_data(rd1),
        .dn_go(go1), .dn_wr(wr1), .dn_addr(da1), .dn_data(dd1), .dn_wait(wait1),
        .execute_enable(exe1), .execute_addr(xa1), .done(done1));
    boot_image_loader #(.IMAGE_LEN(0)) u2 (
        .clk_sys(clk_sys), .reset_n(rst_n2), .start(start2), .rom_addr(ra2), .rom_data(rd2),
        .dn_go(go2), .dn_wr(wr2), .dn_addr(da2), .dn_data(dd2), .dn_wait(zero),
        .execute_enable(exe2), .execute_addr(xa2), .done(done2));
    boot_image_loader #(.DEST_BASE('hFFFE), .IMAGE_LEN(4), .EXEC_ADDR('h1234)) u3 (
        .clk_sys(clk_sys), .reset_n(rst_n3), .start(zero), .rom_addr(ra3), .rom_data(rd3),
        .dn_go(go3), .dn_wr(wr3), .dn_addr(da3), .dn_data(dd3), .dn_wait(zero),
        .execute_enable(exe3), .execute_addr(xa3), .done(done3));
    boot_image_loader #(.AUTO_START(0), .IMAGE_LEN(8)) u4 (
        .clk_sys(clk_sys), .reset_n(rst_n4), .start(start4), .rom_addr(ra4), .rom_data(rd4),
        .dn_go(go4), .dn_wr(wr4), .dn_addr(da4), .dn_data(dd4), .dn_wait(zero),
        .execute_enable(exe4), .execute_addr(xa4), .done(done4));

    wr_t q0[$], q1[$], q3[$], q4[$];
    int ecnt0 = 0, cyc0 = 0, go_at0 = -1, exe_at0 = -1;
    int ecnt1 = 0, w10 = 0, viol1 = 0, ecnt2 = 0, wcnt2 = 0, ecnt3 = 0, ecnt4 = 0;
    logic pw1 = 0;
    logic [15:0] pa1 = 0;
    logic [7:0] pd1 = 0;

    always @(negedge clk_sys)
        if (!rst_n0) begin
            q0.delete();
            ecnt0 <= 0; cyc0 <= 0; go_at0 <= -1; exe_at0 <= -1;
        end else begin
            cyc0 <= cyc0 + 1;
            if (wr0) q0.push_back({da0, dd0});
            if (go0 && go_at0 < 0) go_at0 <= cyc0;
            if (exe0) begin ecnt0 <= ecnt0 + 1; exe_at0 <= cyc0; end
        end

    always @(negedge clk_sys) begin
        if (wr1 && !wait1) q1.push_back({da1, dd1});
        if (wr1 && da1 == 16'd10) w10 <= w10 + 1;
        if (pw1 && (wr1 !== 1'b1 || da1 != pa1 || dd1 != pd1)) viol1 <= viol1 + 1;
        pw1 <= wr1 && wait1;
        pa1 <= da1;
        pd1 <= dd1;
        if (exe1) ecnt1 <= ecnt1 + 1;
    end

    always @(negedge clk_sys) begin
        if (wr2) wcnt2 <= wcnt2 + 1;
        if (exe2) ecnt2 <= ecnt2 + 1;
        if (wr3) q3.push_back({da3, dd3});
        if (exe3) ecnt3 <= ecnt3 + 1;
        if (wr4) q4.push_back({da4, dd4});
        if (exe4) ecnt4 <= ecnt4 + 1;
    end

    initial begin
        vec_t tv[6];
        wr_t tw[4];
        int hold, n10;
        bit stalled;
        tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tv[2] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tv[3] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tv[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tv[5] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tw[0] = {16'hFFFE, rom_f(16'd0)};
        tw[1] = {16'hFFFF, rom_f(16'd1)};
        tw[2] = {16'h0000, rom_f(16'd2)};
        tw[3] = {16'h0001, rom_f(16'd3)};

        repeat (3) @(posedge clk_sys);
        #1;
        check("reset dn_go", go0, 0);
        check("reset dn_wr", wr0, 0);
        check("reset execute_enable", exe0, 0);
        check("reset done", done0, 0);
        check("reset rom_addr", ra0, 0);
        check("reset dn_addr", da0, 0);
        check("reset dn_data", dd0, 0);
        check("u0 execute_addr", xa0, 0);

        rst_n0 = 1;
        for (int c = 0; c < 2000 && ecnt0 < 1; c++) @(negedge clk_sys);
        @(negedge clk_sys);
        check("u0 exec pulses", ecnt0, 1);
        check("u0 write count", q0.size(), 276);
        cmp_copy("u0", q0, 0, 276, 16'h0000);
        check("u0 fetch-to-exec cycles", exe_at0 - go_at0, 552);
        repeat (3) @(negedge clk_sys);
        check("u0 done", done0, 1);
        check("u0 go after done", go0, 0);
        check("u0 single exec", ecnt0, 1);

        @(posedge clk_sys); #1 rst_n0 = 0;
        @(posedge clk_sys); #1 rst_n0 = 1;
        for (int c = 0; c < 1000 && q0.size() < 100; c++) @(negedge clk_sys);
        check("u0 reached word 100", q0.size() >= 100, 1);
        #2 rst_n0 = 0;
        #1;
        check("midreset dn_go", go0, 0);
        check("midreset dn_wr", wr0, 0);
        check("midreset execute_enable", exe0, 0);
        check("midreset done", done0, 0);
        check("midreset rom_addr", ra0, 0);
        check("midreset dn_addr", da0, 0);
        check("midreset dn_data", dd0, 0);
        repeat (3) @(posedge clk_sys);
        #1 rst_n0 = 1;
        for (int c = 0; c < 2000 && ecnt0 < 1; c++) @(negedge clk_sys);
        @(negedge clk_sys);
        check("u0 restart exec pulses", ecnt0, 1);
        check("u0 restart write count", q0.size(), 276);
        cmp_copy("u0 restart", q0, 0, 276, 16'h0000);

        @(posedge clk_sys); #1 rst_n1 = 1;
        stalled = 0;
        hold = 0;
        for (int c = 0; c < 3000 && ecnt1 < 1; c++) begin
            @(posedge clk_sys); #1;
            if (!stalled && wr1 && da1 == 16'd10) begin
                stalled = 1; hold = 5; wait1 = 1;
            end else if (hold > 0) begin
                hold--; wait1 = (hold != 0);
            end else if (stalled) wait1 = ($urandom_range(0, 3) == 0);
        end
        wait1 = 0;
        @(negedge clk_sys);
        check("u1 stall applied", stalled, 1);
        check("u1 exec pulses", ecnt1, 1);
        check("u1 word10 dn_wr cycles", w10, 6);
        check("u1 hold violations", viol1, 0);
        n10 = 0;
        foreach (q1[i]) if (q1[i].a == 16'd10) n10++;
        check("u1 word10 accepted once", n10, 1);
        check("u1 write count", q1.size(), 40);
        cmp_copy("u1", q1, 0, 40, 16'h0000);

        @(posedge clk_sys); #1 rst_n2 = 1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin @(posedge clk_sys); #1; end
            start2 = tv[i].start;
            @(negedge clk_sys);
            check($sformatf("u2 row%0d execute_enable", i), exe2, tv[i].exe);
            check($sformatf("u2 row%0d done", i), done2, tv[i].done);
            check($sformatf("u2 row%0d dn_go", i), go2, tv[i].go);
        end
        start2 = 0;
        check("u2 no writes", wcnt2, 0);

        @(posedge clk_sys); #1 rst_n3 = 1;
        for (int c = 0; c < 100 && ecnt3 < 1; c++) @(negedge clk_sys);
        @(negedge clk_sys);
        check("u3 exec pulses", ecnt3, 1);
        check("u3 write count", q3.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("u3 wrap word %0d", i), (i < q3.size()) ? 32'(q3[i]) : 32'hDEAD_BEEF, 32'(tw[i]));
        check("u3 execute_addr", xa3, 32'h1234);
        check("u3 done", done3, 1);

        @(posedge clk_sys); #1 rst_n4 = 1;
        repeat (5) @(negedge clk_sys);
        check("u4 idle no go", go4, 0);
        check("u4 idle no done", done4, 0);
        check("u4 idle no exec", ecnt4, 0);
        @(posedge clk_sys); #1 start4 = 1;
        @(posedge clk_sys); #1 start4 = 0;
        for (int c = 0; c < 200 && !(wr4 && da4 == 16'd3); c++) @(negedge clk_sys);
        check("u4 saw write 3", wr4 && da4 == 16'd3, 1);
        start4 = 1;
        @(posedge clk_sys); #1 start4 = 0;
        for (int c = 0; c < 200 && ecnt4 < 1; c++) @(negedge clk_sys);
        repeat (3) @(negedge clk_sys);
        check("u4 first exec", ecnt4, 1);
        check("u4 first done", done4, 1);
        check("u4 first write count", q4.size(), 8);
        cmp_copy("u4 copy1", q4, 0, 8, 16'h0000);
        @(posedge clk_sys); #1 start4 = 1;
        @(posedge clk_sys); #1 start4 = 0;
        @(negedge clk_sys);
        check("u4 done cleared", done4, 0);
        for (int c = 0; c < 200 && !(wr4 && da4 == 16'd5); c++) @(negedge clk_sys);
        check("u4 saw write 5", wr4 && da4 == 16'd5, 1);
        start4 = 1;
        @(posedge clk_sys); #1 start4 = 0;
        for (int c = 0; c < 200 && ecnt4 < 2; c++) @(negedge clk_sys);
        repeat (30) @(negedge clk_sys);
        check("u4 second exec", ecnt4, 2);
        check("u4 second done", done4, 1);
        check("u4 total writes", q4.size(), 16);
        cmp_copy("u4 copy2", q4, 8, 8, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/boot_image_loader.md
BOOT_IMAGE_LOADER -- requirements
Module: boot_image_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width of ROM and destination.
REQ-002 SHALL have parameter DATA_W, default 8, data width of ROM and destination.
REQ-003 SHALL have parameter IMAGE_LEN, default 276, number of words copied; range 0..2^ADDR_W.
REQ-004 SHALL have parameter ROM_LAT, default 1, ROM read latency in cycles; range 1..4.
REQ-005 SHALL have parameter DEST_BASE, default 0, first destination address.
REQ-006 SHALL have parameter EXEC_ADDR, default 0, value driven on execute_addr.
REQ-007 SHALL have parameter AUTO_START, default 1, 1 = begin copy automatically after reset release.
REQ-008 SHALL have port clk_sys, input, 1, single system clock; all logic on its rising edge.
REQ-009 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port start, input, 1, one-cycle request to begin a copy.
REQ-011 SHALL have port rom_addr, output, ADDR_W, ROM read address.
REQ-012 SHALL have port rom_data, input, DATA_W, ROM read data, valid ROM_LAT cycles after rom_addr.
REQ-013 SHALL have port dn_go, output, 1, high while a copy is in progress.
REQ-014 SHALL have port dn_wr, output, 1, destination write strobe.
REQ-015 SHALL have port dn_addr, output, ADDR_W, destination write address.
REQ-016 SHALL have port dn_data, output, DATA_W, destination write data.
REQ-017 SHALL have port dn_wait, input, 1, destination stall; write not accepted while high.
REQ-018 SHALL have port execute_enable, output, 1, one-cycle pulse when the copy completes.
REQ-019 SHALL have port execute_addr, output, ADDR_W, constant EXEC_ADDR.
REQ-020 SHALL have port done, output, 1, high from completion until the next copy starts.

Function
REQ-021 SHALL implement states IDLE, FETCH, WRITE, EXEC, DONE with a word index idx of width ADDR_W+1.
REQ-022 SHALL leave IDLE when start=1, or on the first cycle after reset release if AUTO_START=1; idx <= 0.
REQ-023 SHALL, on leaving IDLE or DONE, enter EXEC directly if IMAGE_LEN=0, otherwise enter FETCH.
REQ-024 SHALL, in FETCH, drive rom_addr=idx[ADDR_W-1:0], hold for ROM_LAT cycles, and register rom_data into dn_data on the last of them.
REQ-025 SHALL, in WRITE, assert dn_wr with dn_addr=(DEST_BASE+idx) mod 2^ADDR_W, with dn_data held stable.
REQ-026 SHALL hold WRITE and all dn_* outputs unchanged while dn_wait=1.
REQ-027 SHALL treat a WRITE cycle with dn_wait=0 as accepted; then idx++, and enter EXEC if idx+1=IMAGE_LEN, otherwise FETCH.
REQ-028 SHALL achieve ROM_LAT+1 cycles per word with dn_wait held low.
REQ-029 SHALL assert dn_go in FETCH and WRITE only.
REQ-030 SHALL assert dn_wr in WRITE only.
REQ-031 SHALL drive execute_enable high for exactly the single EXEC cycle, then enter DONE.
REQ-032 SHALL hold done=1 in DONE.
REQ-033 SHALL, when start=1 in DONE, clear done and restart the copy with idx=0.
REQ-034 SHALL ignore start in FETCH, WRITE and EXEC.
REQ-035 SHALL wrap destination address modulo 2^ADDR_W without error.

Reset
REQ-036 SHALL, while reset_n=0 and regardless of clock, force state=IDLE and idx=0.
REQ-037 SHALL, while reset_n=0, drive dn_go, dn_wr, execute_enable, done, rom_addr, dn_addr and dn_data to 0.
REQ-038 SHALL, when reset is asserted mid-copy, abandon the copy immediately with no further dn_wr.
REQ-039 SHALL, when reset is asserted mid-copy and AUTO_START=1, restart the copy from idx=0 after reset release.

Verification
REQ-040 SHALL cover: defaults, dn_wait=0, reset released -> 276 dn_wr pulses at addresses 0..275 with data equal to ROM contents, one execute_enable pulse, 552 cycles from first FETCH to EXEC, then done=1.
REQ-041 SHALL cover: ROM_LAT=3, dn_wait high for 5 cycles during word 10 -> dn_addr=10 and dn_data held over 6 dn_wr cycles, word 10 written exactly once.
REQ-042 SHALL cover: IMAGE_LEN=0, AUTO_START=1 -> no dn_wr, execute_enable on the 2nd cycle after reset release, then done=1.
REQ-043 SHALL cover: DEST_BASE=16'hFFFE, IMAGE_LEN=4 -> writes to FFFE, FFFF, 0000, 0001.
REQ-044 SHALL cover: AUTO_START=0, start pulsed in DONE and again during WRITE -> one full copy per DONE pulse, pulse during WRITE ignored.
REQ-045 SHALL cover: reset_n low at word 100 -> all outputs 0 asynchronously; after release, copy restarts at address 0.
